// File: rtl/toggle_div_pkg.sv
// Shared constants and types for the toggle divider bank.
//   CNT_W_DFLT       : default counter / divisor width
//   DEFAULT_DIV_DFLT : default divisor loaded at reset (period = div+1)
//   div_t            : divisor / counter word at the default width
package toggle_div_pkg;

    localparam int unsigned CNT_W_DFLT       = 32;
    localparam int unsigned DEFAULT_DIV_DFLT = 5;

    typedef logic [CNT_W_DFLT-1:0] div_t;

endpackage

// File: rtl/toggle_div_ch.sv
// One programmable divider channel with a shadowed divisor.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   en           : run enable
//   load_strobe  : accepted config transfer addressed to this channel
//   load_value   : new terminal count
//   count        : current counter value (registered)
//   tick         : one-cycle pulse on the wrap edge (registered)
//   toggle       : flips on every wrap (registered)
//   pending      : a shadowed divisor is waiting for the next wrap
module toggle_div_ch
    import toggle_div_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DFLT,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DFLT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load_strobe,
    input  logic [CNT_W-1:0] load_value,
    output logic [CNT_W-1:0] count,
    output logic             tick,
    output logic             toggle,
    output logic             pending
);

    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] div_shadow;
    logic [CNT_W-1:0] count_nxt;
    logic [CNT_W-1:0] div_nxt;
    logic [CNT_W-1:0] shadow_nxt;
    logic             tick_nxt;
    logic             toggle_nxt;
    logic             pending_nxt;
    logic             wrap;

    assign wrap = (count == div);

    // Next-state: counting, wrap handling and shadow-divisor bookkeeping.
    always_comb begin
        count_nxt   = count;
        div_nxt     = div;
        shadow_nxt  = div_shadow;
        tick_nxt    = 1'b0;
        toggle_nxt  = toggle;
        pending_nxt = pending;

        if (!en) begin
            // A stopped channel is at no risk of glitching, so updates land at once.
            if (load_strobe) begin
                div_nxt     = load_value;
                count_nxt   = '0;
                pending_nxt = 1'b0;
            end else if (pending) begin
                div_nxt     = div_shadow;
                count_nxt   = '0;
                pending_nxt = 1'b0;
            end
        end else begin
            if (wrap) begin
                count_nxt  = '0;
                tick_nxt   = 1'b1;
                toggle_nxt = ~toggle;
                // Uses the registered pending, so a load accepted this cycle waits a period.
                if (pending) begin
                    div_nxt     = div_shadow;
                    pending_nxt = 1'b0;
                end
            end else begin
                count_nxt = count + CNT_W'(1);
            end
            // Only reachable with pending low, since cfg_ready gates it.
            if (load_strobe) begin
                shadow_nxt  = load_value;
                pending_nxt = 1'b1;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count      <= '0;
            div        <= CNT_W'(DEFAULT_DIV);
            div_shadow <= CNT_W'(DEFAULT_DIV);
            tick       <= 1'b0;
            toggle     <= 1'b0;
            pending    <= 1'b0;
        end else begin
            count      <= count_nxt;
            div        <= div_nxt;
            div_shadow <= shadow_nxt;
            tick       <= tick_nxt;
            toggle     <= toggle_nxt;
            pending    <= pending_nxt;
        end
    end

endmodule

// File: rtl/toggle_divider_bank.sv
// Bank of NUM_CH independent programmable toggle dividers with a
// valid/ready configuration port.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   en         : per-channel run enable
//   cfg_valid  : config request
//   cfg_ch     : target channel (out-of-range requests are accepted and dropped)
//   cfg_div    : new terminal count
//   cfg_ready  : config accept (combinational)
//   count      : packed counters, channel i at [i*CNT_W +: CNT_W]
//   tick       : per-channel wrap pulse
//   toggle     : per-channel square output
module toggle_divider_bank
    import toggle_div_pkg::*;
#(
    parameter  int unsigned NUM_CH      = 4,
    parameter  int unsigned CNT_W       = CNT_W_DFLT,
    parameter  int unsigned DEFAULT_DIV = DEFAULT_DIV_DFLT,
    localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       en,
    input  logic                    cfg_valid,
    input  logic [CH_W-1:0]         cfg_ch,
    input  logic [CNT_W-1:0]        cfg_div,
    output logic                    cfg_ready,
    output logic [NUM_CH*CNT_W-1:0] count,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       toggle
);

    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] load_strobe;
    logic              ch_in_range;

    assign ch_in_range = (32'(cfg_ch) < NUM_CH);

    // A busy channel only stalls while it is running; stopped channels load directly.
    always_comb begin
        cfg_ready = 1'b1;
        if (ch_in_range) begin
            cfg_ready = ~pending[cfg_ch] | ~en[cfg_ch];
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign load_strobe[i] = cfg_valid & cfg_ready & ch_in_range & (cfg_ch == CH_W'(i));

        toggle_div_ch #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .en          (en[i]),
            .load_strobe (load_strobe[i]),
            .load_value  (cfg_div),
            .count       (count[i*CNT_W +: CNT_W]),
            .tick        (tick[i]),
            .toggle      (toggle[i]),
            .pending     (pending[i])
        );
    end

endmodule

// File: tb/tb_toggle_divider_bank.sv
module tb_toggle_divider_bank;
    import toggle_div_pkg::*;

    localparam int unsigned NCH = 4;
    localparam int unsigned CW  = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic [NCH-1:0]     en;
    logic               cfg_valid;
    logic [1:0]         cfg_ch;
    div_t               cfg_div;
    logic               cfg_ready;
    logic [NCH*CW-1:0]  count;
    logic [NCH-1:0]     tick;
    logic [NCH-1:0]     toggle;

    always #5 clk = ~clk;

    toggle_divider_bank dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .count     (count),
        .tick      (tick),
        .toggle    (toggle)
    );

    int checks   = 0;
    int failures = 0;
    bit last_acc;

    // Behavioural reference: per-channel state as plain integers.
    int unsigned m_cnt [NCH];
    int unsigned m_div [NCH];
    int unsigned m_sh  [NCH];
    bit          m_pend[NCH];
    bit          m_tick[NCH];
    bit          m_tog [NCH];

    typedef struct {
        logic [3:0]  en;
        logic [31:0] exp_cnt0;
        logic        exp_tick0;
        logic        exp_tog0;
    } vec_t;

    vec_t vt[13];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < NCH; i++) begin
            m_cnt[i] = 0; m_div[i] = 5; m_sh[i] = 5;
            m_pend[i] = 0; m_tick[i] = 0; m_tog[i] = 0;
        end
    endtask

    function automatic bit m_ready(input int ch, input logic [3:0] e);
        if (ch >= NCH) return 1'b1;
        return !m_pend[ch] || !e[ch];
    endfunction

    task automatic m_step(input logic [3:0] e, input bit acc, input int ch, input int unsigned dv);
        for (int i = 0; i < NCH; i++) begin
            bit load;
            load = acc && (ch == i);
            if (!e[i]) begin
                m_tick[i] = 0;
                if (load) begin
                    m_div[i] = dv; m_cnt[i] = 0; m_pend[i] = 0;
                end else if (m_pend[i]) begin
                    m_div[i] = m_sh[i]; m_cnt[i] = 0; m_pend[i] = 0;
                end
            end else begin
                bit was_pending;
                was_pending = m_pend[i];
                if (m_cnt[i] == m_div[i]) begin
                    m_cnt[i] = 0; m_tick[i] = 1; m_tog[i] = !m_tog[i];
                    if (was_pending) begin
                        m_div[i] = m_sh[i]; m_pend[i] = 0;
                    end
                end else begin
                    m_cnt[i] = m_cnt[i] + 1; m_tick[i] = 0;
                end
                if (load) begin
                    m_sh[i] = dv; m_pend[i] = 1;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [127:0] vc;
        logic [3:0]   vt_tick, vt_tog;
        for (int i = 0; i < NCH; i++) begin
            vc[i*CW +: CW] = 32'(m_cnt[i]);
            vt_tick[i]     = m_tick[i];
            vt_tog[i]      = m_tog[i];
        end
        check("count", count, vc);
        check("tick", 128'(tick), 128'(vt_tick));
        check("toggle", 128'(toggle), 128'(vt_tog));
    endtask

    // One clock: check ready against the model, step both across the edge, compare.
    task automatic cycle();
        bit exp_rdy;
        #1;
        exp_rdy  = m_ready(int'(cfg_ch), en);
        check("cfg_ready", 128'(cfg_ready), 128'(exp_rdy));
        last_acc = cfg_valid && exp_rdy;
        @(posedge clk);
        m_step(en, last_acc, int'(cfg_ch), cfg_div);
        @(negedge clk);
        compare_all();
    endtask

    task automatic run_table(input string tag);
        for (int k = 0; k < 13; k++) begin
            en = vt[k].en;
            cycle();
            check({tag, "_cnt0"}, 128'(count[31:0]), 128'(vt[k].exp_cnt0));
            check({tag, "_tick0"}, 128'(tick[0]), 128'(vt[k].exp_tick0));
            check({tag, "_tog0"}, 128'(toggle[0]), 128'(vt[k].exp_tog0));
            check({tag, "_others"}, 128'(count[127:32]), 128'(0));
        end
    endtask

    initial begin
        int unsigned exp_seq[9];
        bit          rdy_seq[9];
        int          phase;
        int          n;

        // ch0 from reset with default divisor 5: period 6, toggle period 12.
        vt[0]  = '{4'b0001, 32'd1, 1'b0, 1'b0};
        vt[1]  = '{4'b0001, 32'd2, 1'b0, 1'b0};
        vt[2]  = '{4'b0001, 32'd3, 1'b0, 1'b0};
        vt[3]  = '{4'b0001, 32'd4, 1'b0, 1'b0};
        vt[4]  = '{4'b0001, 32'd5, 1'b0, 1'b0};
        vt[5]  = '{4'b0001, 32'd0, 1'b1, 1'b1};
        vt[6]  = '{4'b0001, 32'd1, 1'b0, 1'b1};
        vt[7]  = '{4'b0001, 32'd2, 1'b0, 1'b1};
        vt[8]  = '{4'b0001, 32'd3, 1'b0, 1'b1};
        vt[9]  = '{4'b0001, 32'd4, 1'b0, 1'b1};
        vt[10] = '{4'b0001, 32'd5, 1'b0, 1'b1};
        vt[11] = '{4'b0001, 32'd0, 1'b1, 1'b0};
        vt[12] = '{4'b0001, 32'd1, 1'b0, 1'b0};

        rst = 1'b1; en = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
        m_reset();
        repeat (2) @(negedge clk);
        check("rst_count", count, 128'(0));
        check("rst_tick", 128'(tick), 128'(0));
        check("rst_toggle", 128'(toggle), 128'(0));
        check("rst_ready", 128'(cfg_ready), 128'(1));
        rst = 1'b0;

        run_table("default");

        // Shadowed update on ch0 issued at count 2.
        n = 0;
        while (m_cnt[0] != 2 && n < 20) begin cycle(); n++; end
        check("shadow_reach", 128'(count[31:0]), 128'(2));
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 32'd2;
        cycle();
        cfg_valid = 1'b0;
        #1 check("shadow_ready_acc", 128'(cfg_ready), 128'(0));
        check("shadow_cnt_acc", 128'(count[31:0]), 128'(3));
        exp_seq = '{4, 5, 0, 1, 2, 0, 1, 2, 0};
        rdy_seq = '{0, 0, 1, 1, 1, 1, 1, 1, 1};
        for (int j = 0; j < 9; j++) begin
            cycle();
            check("shadow_cnt", 128'(count[31:0]), 128'(exp_seq[j]));
            #1 check("shadow_ready", 128'(cfg_ready), 128'(rdy_seq[j]));
        end

        // Two back-to-back requests to running ch1: the second must stall.
        en = 4'b0011; cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 32'd9;
        phase = 0;
        for (int k = 0; k < 60 && phase < 2; k++) begin
            cfg_div = (phase == 0) ? 32'd9 : 32'd3;
            cycle();
            if (last_acc) begin
                phase++;
                if (phase == 1) #1 check("stall_ready", 128'(cfg_ready), 128'(0));
            end
        end
        check("stall_done", 128'(phase), 128'(2));
        cfg_valid = 1'b0;
        repeat (25) cycle();

        // Direct load of div=0 into stopped ch2, then run it.
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 32'd0;
        cycle();
        cfg_valid = 1'b0;
        en[2] = 1'b1;
        for (int j = 0; j < 6; j++) begin
            cycle();
            check("div0_cnt", 128'(count[95:64]), 128'(0));
            check("div0_tick", 128'(tick[2]), 128'(1));
            check("div0_tog", 128'(toggle[2]), 128'((j % 2 == 0) ? 1 : 0));
        end

        // Enable hold on ch3 at count 4.
        en[3] = 1'b1;
        n = 0;
        while (m_cnt[3] != 4 && n < 20) begin cycle(); n++; end
        en[3] = 1'b0;
        for (int j = 0; j < 10; j++) begin
            cycle();
            check("hold_cnt", 128'(count[127:96]), 128'(4));
            check("hold_tick", 128'(tick[3]), 128'(0));
            check("hold_tog", 128'(toggle[3]), 128'(0));
        end
        en[3] = 1'b1;
        cycle();
        check("resume_cnt", 128'(count[127:96]), 128'(5));

        // Reset with ch0 pending at count 3; the pending value must be lost.
        en = 4'b0000; cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 32'd7;
        cycle();
        cfg_valid = 1'b0; en = 4'b0001;
        n = 0;
        while (m_cnt[0] != 2 && n < 20) begin cycle(); n++; end
        cfg_valid = 1'b1; cfg_div = 32'd4;
        cycle();
        cfg_valid = 1'b0;
        check("pre_rst_cnt", 128'(count[31:0]), 128'(3));
        #2 rst = 1'b1;
        #1;
        check("midrst_count", count, 128'(0));
        check("midrst_tick", 128'(tick), 128'(0));
        check("midrst_toggle", 128'(toggle), 128'(0));
        check("midrst_ready", 128'(cfg_ready), 128'(1));
        m_reset();
        en = '0;
        @(negedge clk);
        rst = 1'b0;
        run_table("post_rst");

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            if (k % 8 == 0) en = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
            cfg_valid = 1'($urandom_range(0, 1));
            cfg_ch    = 2'($urandom_range(0, 3));
            cfg_div   = 32'($urandom_range(0, 7));
            cycle();
        end
        cfg_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/toggle_divider_bank.md
Name: toggle_divider_bank

Overview:
Bank of NUM_CH independent programmable dividers. Each channel counts clk cycles and, at its terminal count, emits a one-cycle tick and flips a toggle output. Each divisor is reprogrammed at run time through a valid/ready config port. Updates are shadowed so that they apply only on a period boundary, which keeps the outputs glitch-free. The bank sits beside the system timebase and drives LED blink, heartbeat and sampling strobes.

Parameters:
NUM_CH, 4, number of channels.
CNT_W, 32, counter and divisor width.
DEFAULT_DIV, 5, divisor loaded into every channel at reset. Period is DEFAULT_DIV+1 cycles.
CH_W, $clog2(NUM_CH) (min 1), channel index width. Derived; not to be overridden.

Ports:
clk  in  1  system clock; all logic on posedge.
rst  in  1  asynchronous active-high reset.
en  in  NUM_CH  per-channel run enable.
cfg_valid  in  1  config request.
cfg_ch  in  CH_W  target channel.
cfg_div  in  CNT_W  new terminal count.
cfg_ready  out  1  config accept; transfer = cfg_valid & cfg_ready.
count  out  NUM_CH*CNT_W  per-channel counter; channel i occupies [i*CNT_W +: CNT_W].
tick  out  NUM_CH  one-cycle terminal pulse, registered.
toggle  out  NUM_CH  square output, registered.

Behaviour:
- Reset (async assert, sync release): count=0, tick=0, toggle=0, div=DEFAULT_DIV, pending=0 for every channel.
- Per channel, state held: div (active), div_shadow, pending flag.
- en=1, count!=div: count <= count+1; tick <= 0.
- en=1, count==div (wrap): count <= 0; tick <= 1; toggle <= ~toggle. Tick and toggle change in the same edge that returns count to 0.
- Resulting waveforms: period is div+1 cycles; toggle period is 2*(div+1).
- div==0: count stays 0, tick is constantly 1, toggle flips every cycle.
- en=0: count and toggle hold their values; tick <= 0.
- en 0->1: counting resumes from the held count. There is no restart.
- Counter width: modulo CNT_W. Overflow is impossible because count never exceeds div.
- Live div reduced below the current count: not reachable, because updates apply only at a wrap or while the channel is disabled.
- Config handshake:
  - cfg_ready = ~pending[cfg_ch] | ~en[cfg_ch] (combinational).
  - Out-of-range cfg_ch (>=NUM_CH): cfg_ready=1; the request is accepted and dropped.
- Accepted transfer to an enabled channel:
  - Next edge: div_shadow <= cfg_div; pending <= 1.
  - At the first wrap strictly after the acceptance cycle: div <= div_shadow; pending <= 0.
  - The wrap that occurs in the acceptance cycle itself still uses the old div.
- Accepted transfer to a disabled channel: next edge div <= cfg_div, count <= 0, pending <= 0. toggle holds.
- Channel disabled while pending=1: next edge div <= div_shadow, count <= 0, pending <= 0.
- Simultaneous config on one channel and wraps on others: fully independent; no interaction between channels.
- Back-to-back requests to the same enabled channel: the second request stalls (cfg_ready=0) until pending clears.
- Reset mid-operation: every state element returns to its reset value immediately. Any pending update is discarded.

Decomposition:
- Package toggle_div_pkg: DEFAULT_DIV default and CNT_W default localparams, plus typedef div_t = logic [CNT_W-1:0].
- Sub-module toggle_div_ch: one channel, holding count, div, div_shadow, pending, tick and toggle.
  - Inputs: en, load_strobe, load_value.
  - Output: pending, used by the top to form cfg_ready.
- Top: cfg_ch decode, cfg_ready mux, count packing, and a generate loop over NUM_CH.

Test Plan:
- Reset default: release rst with en=4'b0001 -> ch0 count goes 0,1..5,0; tick[0] high in every 6th cycle; toggle[0] period 12 cycles. Channels 1-3 stay at 0.
- Shadowed update: ch0 running div=5; at count=2 send cfg_div=2 -> the current period still ends at 5; the next periods run 0,1,2,0; cfg_ready for ch0 is low from acceptance until that wrap.
- Stall: two consecutive valid requests to ch1 (enabled), div 9 then 3 -> the second request is held with cfg_ready=0 until the first applies; it then applies at the following wrap.
- Disabled load and div=0: en[2]=0, load cfg_div=0, then set en[2]=1 -> count[2]=0, tick[2] constantly 1, toggle[2] alternates every cycle.
- Enable hold: drop en[3] at count=4 for 10 cycles -> count[3] stays 4, toggle holds, tick=0; raising en again resumes at 5.
- Reset mid-op: assert rst while ch0 has pending=1 and count=3 -> all outputs 0 and cfg_ready=1 immediately; after release, ch0 div=5 (the pending value is lost).
